dual_bank_regfile: RTL
======================

// Module: dual_bank_regfile
// PURPOSE
//  Integer + float architectural register file for the core: NRD parametrised read ports, one write port.
//  Adds same-cycle write->read bypass, a hardwired-zero int r0, and a per-register busy scoreboard.
//  Sits between decode (read/issue) and writeback (write); iss_ready and rd_busy feed the stall logic.
// PARAMETERS
//  XLEN   32  data width of every register, both banks
//  NREG   32  registers per bank; power of two, >=2; AW = $clog2(NREG)
//  NRD    2   number of read ports, 1..4
//  ZERO_R0 1  1: int r0 reads 0, ignores writes, never busy; float f0 is always a normal register
// PORTS
//  clk        in   1         clock, all state updates on rising edge
//  rstn       in   1         asynchronous active-low reset
//  rd_fmode   in   NRD       per read port bank select: 0=int, 1=float
//  rd_addr    in   NRD*AW    per read port register index, port i at [i*AW +: AW]
//  rd_data    out  NRD*XLEN  per read port data, port i at [i*XLEN +: XLEN]
//  rd_busy    out  NRD       per read port: addressed register awaits a writeback
//  wenable    in   1         write strobe
//  wfmode     in   1         write bank: 0=int, 1=float
//  wreg       in   AW        write register index
//  wdata      in   XLEN      write data
//  iss_valid  in   1         decode issues an instruction with a destination
//  iss_fmode  in   1         destination bank
//  iss_reg    in   AW        destination index
//  iss_ready  out  1         destination may be claimed this cycle
// BEHAVIOUR
//  Reset (async, rstn=0): all registers in both banks = 0; all busy bits = 0. Effect is immediate, mid-operation included.
//   While rstn=0: rd_data = 0, rd_busy = 0, iss_ready = 0, and writes and issues are ignored.
//  Write: at the rising edge with wenable=1, bank[wfmode][wreg] <= wdata.
//   A write to int r0 with ZERO_R0=1 is dropped.
//  Read: combinational, zero-cycle latency, all NRD ports independent.
//   Ports may address the same register or different banks in the same cycle.
//  Bypass: a port where wenable=1, rd_fmode==wfmode and rd_addr==wreg returns wdata in that same cycle.
//   Exception: int r0 with ZERO_R0=1, which returns 0.
//   Bank select is part of the match: int r5 write never bypasses to a float r5 read.
//  Scoreboard: one busy bit per register per bank.
//   Claim: iss_valid && iss_ready sets busy[iss_fmode][iss_reg] at the edge.
//   Clear: wenable clears busy[wfmode][wreg] at the edge.
//   Claim and clear on the same register in the same edge: claim wins, busy stays 1 (new producer).
//   A write to a non-busy register is legal and leaves busy at 0.
//  iss_ready = !busy[iss_fmode][iss_reg] || (wenable && wfmode==iss_fmode && wreg==iss_reg).
//   WAW stall, released by a same-cycle writeback.
//   Int r0 with ZERO_R0=1: iss_ready=1 and no busy bit is ever set.
//   iss_ready does not depend on iss_valid (no combinational loop through iss_valid).
//  rd_busy[i] = busy[rd_fmode][rd_addr] && !(bypass hit on port i). A bypassed read is never reported busy.
//  No other state: there are no counters and no FSM beyond the 2*NREG busy bits and the register arrays.
//  Out-of-range indices cannot occur (NREG = 2**AW).
// STRUCTURE
//  Package regfile_pkg:
//   - XLEN default
//   - typedef bank_t {BANK_INT=0, BANK_FLT=1}
//   - function for the slice of port i
//  Sub-module regfile_bank, instantiated twice (int with ZERO_R0, float with 0). Each instance owns:
//   - the NREG x XLEN array
//   - the NREG-bit busy vector
//   - NRD read muxes with bypass
//   - its own claim/clear decode
//  This module: bank steering of read/write/issue, rd_data/rd_busy output muxing, iss_ready.
// TESTING
//  1. Reset sequence:
//     - Reset, then read int r1 and float r2 -> rd_data=0, rd_busy=0.
//     - Write int r3=0x1234, next cycle read r3 -> 0x1234.
//  2. Write int r0=0xFFFFFFFF; read int r0 -> 0.
//     Write float f0=0xDEAD; read f0 -> 0xDEAD.
//  3. Bypass and bank isolation:
//     - Same cycle: write int r5=0xA5, port0 reads int r5 -> 0xA5.
//     - Port1 reads float r5 -> old float value, not 0xA5.
//  4. Scoreboard:
//     - Issue float r7 -> busy.
//     - Next cycle: iss_ready=0 for f7, rd_busy=1 for f7.
//     - Write f7=0x3F800000 -> same cycle rd_busy=0, data bypassed; next cycle busy=0.
//  5. Simultaneous claim/clear: busy int r9; same edge wenable r9 + iss_valid r9 -> iss_ready=1, busy remains 1.
//  6. Async reset mid-operation:
//     - With several busy bits set, pulse rstn low between edges.
//     - Immediately: all rd_data=0, rd_busy=0, iss_ready=0.
//     - After release: every register reads 0.
//  Repeat 1-6 with NRD=1, NRD=4, NREG=8, XLEN=64.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the dual-bank (int + float) register file.
package regfile_pkg;

   // Default data width of every register in both banks.
   localparam int XLEN_DEF = 32;

   // Bank select encoding used on every read, write and issue port.
   typedef enum logic {
      BANK_INT = 1'b0,
      BANK_FLT = 1'b1
   } bank_t;

   // Low bit of port `port` inside a flat vector of `width`-bit fields.
   function automatic int port_lo(input int port, input int width);
      return port * width;
   endfunction

endpackage

// File: rtl/regfile_bank.sv
// One register bank: storage array, busy scoreboard, NRD bypassing read muxes
// and the bank-local claim/clear decode. ZERO_R0 hardwires entry 0 to zero.
module regfile_bank
   import regfile_pkg::*;
#(
   parameter int XLEN    = XLEN_DEF,
   parameter int NREG    = 32,
   parameter int NRD     = 2,
   parameter bit ZERO_R0 = 1'b0,
   parameter int AW      = $clog2(NREG)
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_busy,
   input  logic                wenable,
   input  logic [AW-1:0]       wreg,
   input  logic [XLEN-1:0]     wdata,
   input  logic                claim,
   input  logic [AW-1:0]       iss_reg,
   output logic                iss_busy
);

   logic [XLEN-1:0] regs [NREG];
   logic [NREG-1:0] busy;
   logic [NREG-1:0] busy_nxt;
   logic            wr_ok;
   logic            claim_ok;

   // A write or claim aimed at a hardwired-zero r0 is simply discarded.
   assign wr_ok    = wenable && !(ZERO_R0 && (wreg == '0));
   assign claim_ok = claim && !(ZERO_R0 && (iss_reg == '0));
   assign iss_busy = busy[iss_reg];

   // Register array: async clear, one write per edge.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int k = 0; k < NREG; k++) regs[k] <= '0;
      end else if (wr_ok) begin
         regs[wreg] <= wdata;
      end
   end

   // Scoreboard next state: writeback clears first, so a same-edge claim wins.
   always_comb begin
      busy_nxt = busy;
      if (wenable) busy_nxt[wreg] = 1'b0;
      if (claim_ok) busy_nxt[iss_reg] = 1'b1;
   end

   // Scoreboard register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) busy <= '0;
      else       busy <= busy_nxt;
   end

   // Read muxes: zero register first, then same-cycle bypass, then the array.
   always_comb begin
      logic [AW-1:0] addr;
      addr    = '0;
      rd_data = '0;
      rd_busy = '0;
      for (int i = 0; i < NRD; i++) begin
         addr = rd_addr[port_lo(i, AW) +: AW];
         if (ZERO_R0 && (addr == '0)) begin
            rd_data[port_lo(i, XLEN) +: XLEN] = '0;
         end else if (wenable && (addr == wreg)) begin
            rd_data[port_lo(i, XLEN) +: XLEN] = wdata;
         end else begin
            rd_data[port_lo(i, XLEN) +: XLEN] = regs[addr];
            rd_busy[i]                        = busy[addr];
         end
      end
   end

endmodule

// File: rtl/dual_bank_regfile.sv
// Integer + float architectural register file with write->read bypass,
// hardwired-zero int r0 and a per-register busy scoreboard for WAW stalls.
module dual_bank_regfile
   import regfile_pkg::*;
#(
   parameter int XLEN    = XLEN_DEF,
   parameter int NREG    = 32,
   parameter int NRD     = 2,
   parameter bit ZERO_R0 = 1'b1,
   localparam int AW     = $clog2(NREG)
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic [NRD-1:0]      rd_fmode,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_busy,
   input  logic                wenable,
   input  logic                wfmode,
   input  logic [AW-1:0]       wreg,
   input  logic [XLEN-1:0]     wdata,
   input  logic                iss_valid,
   input  logic                iss_fmode,
   input  logic [AW-1:0]       iss_reg,
   output logic                iss_ready
);

   logic [NRD*XLEN-1:0] int_data, flt_data;
   logic [NRD-1:0]      int_busy, flt_busy;
   logic                int_iss_busy, flt_iss_busy;
   logic                int_we, flt_we;
   logic                iss_busy, iss_release;

   assign int_we = wenable && (wfmode == BANK_INT);
   assign flt_we = wenable && (wfmode == BANK_FLT);

   // WAW stall unless the current producer writes back this very cycle.
   // Deliberately independent of iss_valid.
   assign iss_busy    = (iss_fmode == BANK_FLT) ? flt_iss_busy : int_iss_busy;
   assign iss_release = wenable && (wfmode == iss_fmode) && (wreg == iss_reg);
   assign iss_ready   = rstn && (!iss_busy || iss_release);

   regfile_bank #(
      .XLEN(XLEN), .NREG(NREG), .NRD(NRD), .ZERO_R0(ZERO_R0), .AW(AW)
   ) u_int_bank (
      .clk(clk), .rstn(rstn),
      .rd_addr(rd_addr), .rd_data(int_data), .rd_busy(int_busy),
      .wenable(int_we), .wreg(wreg), .wdata(wdata),
      .claim(iss_valid && iss_ready && (iss_fmode == BANK_INT)),
      .iss_reg(iss_reg), .iss_busy(int_iss_busy)
   );

   regfile_bank #(
      .XLEN(XLEN), .NREG(NREG), .NRD(NRD), .ZERO_R0(1'b0), .AW(AW)
   ) u_flt_bank (
      .clk(clk), .rstn(rstn),
      .rd_addr(rd_addr), .rd_data(flt_data), .rd_busy(flt_busy),
      .wenable(flt_we), .wreg(wreg), .wdata(wdata),
      .claim(iss_valid && iss_ready && (iss_fmode == BANK_FLT)),
      .iss_reg(iss_reg), .iss_busy(flt_iss_busy)
   );

   // Per-port bank steering; everything reads as idle while reset is held.
   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      for (int i = 0; i < NRD; i++) begin
         if (rstn) begin
            if (rd_fmode[i] == BANK_FLT) begin
               rd_data[port_lo(i, XLEN) +: XLEN] = flt_data[port_lo(i, XLEN) +: XLEN];
               rd_busy[i]                        = flt_busy[i];
            end else begin
               rd_data[port_lo(i, XLEN) +: XLEN] = int_data[port_lo(i, XLEN) +: XLEN];
               rd_busy[i]                        = int_busy[i];
            end
         end
      end
   end

endmodule
